// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I writeback and register file.
package rv_pkg;
  localparam int XLEN_C = 32;
  localparam int AW_C   = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;
endpackage

// File: rtl/wb_result_mux.sv
// Per-lane writeback result select with a legality flag.
// A lane built with HAS_MEM=0 has no load path, so RES_MEM is illegal on it.
module wb_result_mux
  import rv_pkg::*;
#(
  parameter int XLEN    = XLEN_C,
  parameter bit HAS_MEM = 1'b1
) (
  input  logic [1:0]      src,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] mem,
  input  logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] result,
  output logic            legal
);

  // Illegal selects drive zero so forwarding never sees stale data.
  always_comb begin
    result = '0;
    legal  = 1'b0;
    case (src)
      RES_ALU: begin
        result = alu;
        legal  = 1'b1;
      end
      RES_MEM: begin
        if (HAS_MEM) begin
          result = mem;
          legal  = 1'b1;
        end
      end
      RES_PC4: begin
        result = pc4;
        legal  = 1'b1;
      end
      default: begin
        result = '0;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_regfile_dual.sv
// Dual-lane writeback stage and 32x32 register file with two write and four read ports.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile_dual
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_C,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteW_0,
  input  logic [1:0]      ResultSrcW_0,
  input  logic [XLEN-1:0] AluResultW_0,
  input  logic [AW-1:0]   RdW_0,
  input  logic [XLEN-1:0] PCPlus4W_0,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [XLEN-1:0] AluResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [AW-1:0]   Rs1D_0,
  input  logic [AW-1:0]   Rs2D_0,
  input  logic [AW-1:0]   Rs1D_1,
  input  logic [AW-1:0]   Rs2D_1,
  output logic [XLEN-1:0] RD1D_0,
  output logic [XLEN-1:0] RD2D_0,
  output logic [XLEN-1:0] RD1D_1,
  output logic [XLEN-1:0] RD2D_1,
  output logic [XLEN-1:0] ResultW_0,
  output logic [XLEN-1:0] ResultW_1,
  output logic            WbErr
);

  logic            legal_0, legal_1;
  logic            we_0, we_1;
  logic            err_set;
  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   ra   [4];
  logic [XLEN-1:0] rdat [4];

  wb_result_mux #(.XLEN(XLEN), .HAS_MEM(1'b0)) u_mux_0 (
    .src    (ResultSrcW_0),
    .alu    (AluResultW_0),
    .mem    ('0),
    .pc4    (PCPlus4W_0),
    .result (ResultW_0),
    .legal  (legal_0)
  );

  wb_result_mux #(.XLEN(XLEN), .HAS_MEM(1'b1)) u_mux_1 (
    .src    (ResultSrcW),
    .alu    (AluResultW),
    .mem    (ReadDataW),
    .pc4    (PCPlus4W),
    .result (ResultW_1),
    .legal  (legal_1)
  );

  assign we_0    = RegWriteW_0 && (RdW_0 != '0) && legal_0;
  assign we_1    = RegWriteW   && (RdW   != '0) && legal_1;
  assign err_set = (RegWriteW_0 && !legal_0) || (RegWriteW && !legal_1);

  // WB -> register file boundary; lane 1 is younger, so its write lands last.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      WbErr <= 1'b0;
    end else begin
      if (we_0) regs[RdW_0] <= ResultW_0;
      if (we_1) regs[RdW]   <= ResultW_1;
      if (err_set) WbErr <= 1'b1;
    end
  end

  assign ra[0] = Rs1D_0;
  assign ra[1] = Rs2D_0;
  assign ra[2] = Rs1D_1;
  assign ra[3] = Rs2D_1;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdat[p] = regs[ra[p]];
`ifdef REGFILE_BYPASS_EN
      if (we_0 && (ra[p] == RdW_0)) rdat[p] = ResultW_0;
      if (we_1 && (ra[p] == RdW))   rdat[p] = ResultW_1;
`endif
      if (ra[p] == '0) rdat[p] = '0;
    end
  end

  assign RD1D_0 = rdat[0];
  assign RD2D_0 = rdat[1];
  assign RD1D_1 = rdat[2];
  assign RD2D_1 = rdat[3];

endmodule

// File: tb/tb_wb_regfile_dual.sv
// Directed bench for wb_regfile_dual; honours REGFILE_BYPASS_EN for bypass expectations.
module tb_wb_regfile_dual;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW_0;
  logic [1:0]  ResultSrcW_0;
  logic [31:0] AluResultW_0;
  logic [4:0]  RdW_0;
  logic [31:0] PCPlus4W_0;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] AluResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic [4:0]  Rs1D_0, Rs2D_0, Rs1D_1, Rs2D_1;
  logic [31:0] RD1D_0, RD2D_0, RD1D_1, RD2D_1;
  logic [31:0] ResultW_0, ResultW_1;
  logic        WbErr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_regfile_dual dut (
    .clk(clk), .rst(rst),
    .RegWriteW_0(RegWriteW_0), .ResultSrcW_0(ResultSrcW_0), .AluResultW_0(AluResultW_0),
    .RdW_0(RdW_0), .PCPlus4W_0(PCPlus4W_0),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .AluResultW(AluResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .Rs1D_0(Rs1D_0), .Rs2D_0(Rs2D_0), .Rs1D_1(Rs1D_1), .Rs2D_1(Rs2D_1),
    .RD1D_0(RD1D_0), .RD2D_0(RD2D_0), .RD1D_1(RD1D_1), .RD2D_1(RD2D_1),
    .ResultW_0(ResultW_0), .ResultW_1(ResultW_1), .WbErr(WbErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RegWriteW_0 = 1'b0; ResultSrcW_0 = 2'b00; AluResultW_0 = '0; RdW_0 = '0; PCPlus4W_0 = '0;
    RegWriteW   = 1'b0; ResultSrcW   = 2'b00; AluResultW   = '0; ReadDataW = '0; RdW = '0;
    PCPlus4W    = '0;
  endtask

  task automatic read_all(input logic [4:0] a);
    Rs1D_0 = a; Rs2D_0 = a; Rs1D_1 = a; Rs2D_1 = a;
    #1;
  endtask

  logic [31:0] exp_byp;

  initial begin
    idle();
    read_all(5'd0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    read_all(5'd5);
    check("reset_x5", RD1D_0, 32'h0);
    check("reset_err", {31'b0, WbErr}, 32'h0);

    // Lane 0 ALU write to x5
    RegWriteW_0 = 1'b1; ResultSrcW_0 = 2'b00; AluResultW_0 = 32'h1234; RdW_0 = 5'd5;
    #1;
    check("fwd0_alu", ResultW_0, 32'h1234);
    tick();
    idle();
    read_all(5'd5);
    check("x5_rd1_0", RD1D_0, 32'h0000_1234);
    check("x5_rd2_1", RD2D_1, 32'h0000_1234);

    // Both lanes write x7, lane 1 wins
    RegWriteW_0 = 1'b1; AluResultW_0 = 32'hAAAA; RdW_0 = 5'd7;
    RegWriteW   = 1'b1; AluResultW   = 32'hBBBB; RdW   = 5'd7;
    tick();
    idle();
    read_all(5'd7);
    check("x7_rd1_0", RD1D_0, 32'hBBBB);
    check("x7_rd2_0", RD2D_0, 32'hBBBB);
    check("x7_rd1_1", RD1D_1, 32'hBBBB);
    check("x7_rd2_1", RD2D_1, 32'hBBBB);

    // Lane 1 load to x0 is dropped
    RegWriteW = 1'b1; ResultSrcW = 2'b01; ReadDataW = 32'hDEADBEEF; RdW = 5'd0;
    #1;
    check("fwd1_mem", ResultW_1, 32'hDEADBEEF);
    tick();
    idle();
    read_all(5'd0);
    check("x0_zero", RD2D_1, 32'h0);
    read_all(5'd5);
    check("x5_keep", RD1D_1, 32'h1234);
    read_all(5'd7);
    check("x7_keep", RD2D_0, 32'hBBBB);
    check("err_clean", {31'b0, WbErr}, 32'h0);

    // PC+4 on both lanes to different registers
    RegWriteW_0 = 1'b1; ResultSrcW_0 = 2'b10; PCPlus4W_0 = 32'h200; AluResultW_0 = 32'h9; RdW_0 = 5'd10;
    RegWriteW   = 1'b1; ResultSrcW   = 2'b10; PCPlus4W   = 32'h100; AluResultW   = 32'h8; RdW   = 5'd8;
    tick();
    idle();
    read_all(5'd10);
    check("x10_pc4", RD1D_0, 32'h200);
    read_all(5'd8);
    check("x8_pc4", RD2D_1, 32'h100);

    // Illegal load select on lane 0
    RegWriteW_0 = 1'b1; ResultSrcW_0 = 2'b01; AluResultW_0 = 32'h77; RdW_0 = 5'd3;
    #1;
    check("fwd0_illegal", ResultW_0, 32'h0);
    check("err_pre_edge", {31'b0, WbErr}, 32'h0);
    tick();
    idle();
    read_all(5'd3);
    check("x3_unchanged", RD1D_0, 32'h0);
    check("err_set", {31'b0, WbErr}, 32'h1);

    // Lane 1 select 11 is illegal too
    ResultSrcW = 2'b11; AluResultW = 32'h5; PCPlus4W = 32'h6;
    #1;
    check("fwd1_illegal", ResultW_1, 32'h0);
    idle();

    // Bypass: x9 old 0x11, new 0x55 on lane 1
    RegWriteW_0 = 1'b1; ResultSrcW_0 = 2'b00; AluResultW_0 = 32'h11; RdW_0 = 5'd9;
    tick();
    idle();
    RegWriteW = 1'b1; ResultSrcW = 2'b00; AluResultW = 32'h55; RdW = 5'd9;
    Rs2D_1 = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h55;
`else
    exp_byp = 32'h11;
`endif
    check("bypass_x9", RD2D_1, exp_byp);
    tick();
    idle();
    #1;
    check("x9_after", RD2D_1, 32'h55);

    // Bypass priority when both lanes write x11
    RegWriteW_0 = 1'b1; AluResultW_0 = 32'h66; RdW_0 = 5'd11;
    RegWriteW   = 1'b1; AluResultW   = 32'h77; RdW   = 5'd11;
    Rs1D_0 = 5'd11;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h77;
`else
    exp_byp = 32'h0;
`endif
    check("bypass_x11", RD1D_0, exp_byp);
    tick();
    idle();
    check("err_sticky", {31'b0, WbErr}, 32'h1);

    // Fill x1..x31
    for (int i = 1; i < 32; i++) begin
      RegWriteW_0 = 1'b1; ResultSrcW_0 = 2'b00; RdW_0 = 5'(i);
      AluResultW_0 = 32'h0101_0101 * i;
      tick();
    end
    idle();
    read_all(5'd31);
    check("x31_loaded", RD1D_1, 32'h1F1F_1F1F);
    read_all(5'd4);
    check("x4_loaded", RD2D_0, 32'h0404_0404);

    // Reset with a concurrent write to x4
    rst = 1'b0;
    RegWriteW_0 = 1'b1; ResultSrcW_0 = 2'b00; AluResultW_0 = 32'hFFFF; RdW_0 = 5'd4;
    tick();
    rst = 1'b1;
    idle();
    for (int i = 1; i < 32; i++) begin
      read_all(5'(i));
      check($sformatf("clr_x%0d", i), RD1D_0, 32'h0);
    end
    check("clr_err", {31'b0, WbErr}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
